// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared definitions for the reaction-timer controller: state encoding,
// LFSR seed/tap mask, result width and the default saturation value.
package reaction_timer_ctrl_pkg;

    localparam int          RESULT_W         = 14;
    localparam int          DEFAULT_MAX_TIME = 9999;
    localparam logic [15:0] LFSR_SEED        = 16'hACE1;
    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS        = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_GO    = 3'd2,
        ST_SHOW  = 3'd3,
        ST_EARLY = 3'd4
    } state_t;

    // One Galois step: shift right, fold the dropped bit back through the taps
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Signal bundle between the trial controller and its surroundings.
// start/react are single-cycle pulses from upstream debouncers: a pulse is
// consumed on the clock edge it is high, there is no ready/back-pressure, and
// a pulse arriving in a state that ignores it is simply dropped.
// state and lfsr are observation-only copies of internal registers.
interface reaction_timer_ctrl_if;
    import reaction_timer_ctrl_pkg::*;

    logic                start;
    logic                react;
    logic [RESULT_W-1:0] rect_time;
    logic                disp_en;
    logic                led_go;
    logic                too_early;
    logic                busy;
    state_t              state;
    logic [15:0]         lfsr;

    modport master (
        output start, react,
        input  rect_time, disp_en, led_go, too_early, busy, state, lfsr
    );

    modport slave (
        input  start, react,
        output rect_time, disp_en, led_go, too_early, busy, state, lfsr
    );

endinterface

// File: rtl/reaction_timer_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every clock, restarts from the
// seed on reset. A maximal-length polynomial keeps it out of the all-zero state.
module reaction_timer_ctrl_lfsr16
    import reaction_timer_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        en,
    output logic [15:0] q
);

    // Shift register with asynchronous active-low reset to the seed
    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time trial sequencer: random wait, GO indication, tick counting
// until the react press, result hold, and too-early detection. All outputs
// are registers loaded from the next state so the display enable is glitch-free.
module reaction_timer_ctrl
    import reaction_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int MIN_DELAY = 1000,
    parameter int RAND_BITS = 11,
    parameter int MAX_TIME  = DEFAULT_MAX_TIME
) (
    input  logic                 clk,
    input  logic                 en,
    reaction_timer_ctrl_if.slave bus
);

    localparam int PRESC_W  = $clog2(TICK_DIV);
    localparam int SUM_BITS = $clog2(MIN_DELAY + (1 << RAND_BITS));
    // Wide enough for MIN_DELAY + max random offset without truncation
    localparam int DLY_W    = ((RAND_BITS + 1) > SUM_BITS) ? (RAND_BITS + 1) : SUM_BITS;

    state_t              state_q, state_d;
    logic [RESULT_W-1:0] rect_q, rect_d;
    logic [PRESC_W-1:0]  presc_q;
    logic [DLY_W-1:0]    delay_q;
    logic [DLY_W-1:0]    delay_load;
    logic [15:0]         lfsr_q;
    logic                tick;
    logic                enter_timed;
    logic                led_go_q, too_early_q, busy_q, disp_en_q;

    reaction_timer_ctrl_lfsr16 u_lfsr (
        .clk (clk),
        .en  (en),
        .q   (lfsr_q)
    );

    assign tick        = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign enter_timed = (state_d != state_q) &&
                         ((state_d == ST_WAIT) || (state_d == ST_GO));
    assign delay_load  = DLY_W'(MIN_DELAY) +
                         {{(DLY_W - RAND_BITS){1'b0}}, lfsr_q[RAND_BITS-1:0]};

    // Next-state and next-result decode; react beats expiry, start beats react
    always_comb begin
        state_d = state_q;
        rect_d  = rect_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.react) begin
                    state_d = ST_EARLY;
                end else if (tick && (delay_q == DLY_W'(1))) begin
                    state_d = ST_GO;
                    rect_d  = '0;
                end
            end
            ST_GO: begin
                if (bus.react) begin
                    state_d = ST_SHOW;
                end else if (tick) begin
                    if ((rect_q + RESULT_W'(1)) >= RESULT_W'(MAX_TIME)) begin
                        rect_d  = RESULT_W'(MAX_TIME);
                        state_d = ST_SHOW;
                    end else begin
                        rect_d = rect_q + RESULT_W'(1);
                    end
                end
            end
            ST_SHOW: begin
                if (bus.start) state_d = ST_WAIT;
            end
            ST_EARLY: begin
                if (bus.start) state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, result and output registers, outputs decoded from the next state
    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            state_q     <= ST_IDLE;
            rect_q      <= '0;
            led_go_q    <= 1'b0;
            too_early_q <= 1'b0;
            busy_q      <= 1'b0;
            disp_en_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            rect_q      <= rect_d;
            led_go_q    <= (state_d == ST_GO);
            too_early_q <= (state_d == ST_EARLY);
            busy_q      <= (state_d == ST_WAIT) || (state_d == ST_GO);
            disp_en_q   <= !((state_d == ST_WAIT) || (state_d == ST_EARLY));
        end
    end

    // Tick prescaler, restarted on WAIT/GO entry so the first tick is a full period later
    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            presc_q <= '0;
        end else if (enter_timed || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    // Random-wait counter: loaded on WAIT entry, decremented once per tick while waiting
    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            delay_q <= '0;
        end else if (enter_timed && (state_d == ST_WAIT)) begin
            delay_q <= delay_load;
        end else if ((state_q == ST_WAIT) && tick) begin
            delay_q <= delay_q - DLY_W'(1);
        end
    end

    assign bus.rect_time = rect_q;
    assign bus.led_go    = led_go_q;
    assign bus.too_early = too_early_q;
    assign bus.busy      = busy_q;
    assign bus.disp_en   = disp_en_q;
    assign bus.state     = state_q;
    assign bus.lfsr      = lfsr_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with small timing parameters.
module tb_reaction_timer_ctrl;
    import reaction_timer_ctrl_pkg::*;

    localparam int TICK_DIV  = 4;
    localparam int MIN_DELAY = 8;
    localparam int RAND_BITS = 3;
    localparam int MAX_TIME  = 20;

    // ---------------- clock / reset ----------------
    logic clk;
    logic en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reaction_timer_ctrl_if bus();

    reaction_timer_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .MIN_DELAY (MIN_DELAY),
        .RAND_BITS (RAND_BITS),
        .MAX_TIME  (MAX_TIME)
    ) dut (
        .clk (clk),
        .en  (en),
        .bus (bus)
    );

    // ---------------- reference LFSR model ----------------
    logic [15:0] m_lfsr;

    function automatic logic [15:0] model_next(input logic [15:0] c);
        logic [15:0] n;
        n[15]  = c[0];
        n[14]  = c[15];
        n[13]  = c[14] ^ c[0];
        n[12]  = c[13] ^ c[0];
        n[11]  = c[12];
        n[10]  = c[11] ^ c[0];
        n[9:0] = c[10:1];
        return n;
    endfunction

    always @(posedge clk or negedge en) begin
        if (!en) m_lfsr <= 16'hACE1;
        else     m_lfsr <= model_next(m_lfsr);
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic r);
        bus.start = s;
        bus.react = r;
        step();
        bus.start = 1'b0;
        bus.react = 1'b0;
    endtask

    // Start a trial; the model predicts the delay from the LFSR value seen at the start edge
    task automatic start_trial(input logic with_react);
        exp_q.push_back(8'(MIN_DELAY + int'(m_lfsr[2:0])));
        pulse(1'b1, with_react);
    endtask

    // Wait (bounded) for GO and compare the latency with the predicted delay
    task automatic wait_go(input string tag, output int ticks);
        int n;
        int d;
        n = 0;
        d = 0;
        if (exp_q.size() != 0) d = int'(exp_q.pop_front());
        do begin
            step();
            n++;
        end while (!bus.led_go && n < 80);
        check(tag, 32'(n), 32'(TICK_DIV * d));
        ticks = n / TICK_DIV;
    endtask

    int          t;
    int          d_peek;
    int          got[8];
    logic        seen_go;
    logic        in_range;
    logic        all_eq;

    // ---------------- directed sequence ----------------
    initial begin
        en        = 1'b0;
        bus.start = 1'b0;
        bus.react = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset values
        check("rst_rect",      32'(bus.rect_time), 32'd0);
        check("rst_disp_en",   32'(bus.disp_en),   32'd1);
        check("rst_led_go",    32'(bus.led_go),    32'd0);
        check("rst_too_early", 32'(bus.too_early), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_state",     32'(bus.state),     32'(ST_IDLE));
        check("rst_lfsr",      32'(bus.lfsr),      32'h0000ACE1);

        en = 1'b1;
        repeat (5) step();
        check("idle_hold",     32'(bus.state),     32'(ST_IDLE));
        check("lfsr_model_a",  32'(bus.lfsr),      32'(m_lfsr));

        // reset in the middle of GO
        start_trial(1'b0);
        wait_go("go_lat_first", t);
        repeat (6) step();
        check("pre_rst_rect",  32'(bus.rect_time), 32'd1);
        #3 en = 1'b0;
        #1;
        check("mid_rst_rect",      32'(bus.rect_time), 32'd0);
        check("mid_rst_disp_en",   32'(bus.disp_en),   32'd1);
        check("mid_rst_led_go",    32'(bus.led_go),    32'd0);
        check("mid_rst_too_early", 32'(bus.too_early), 32'd0);
        check("mid_rst_busy",      32'(bus.busy),      32'd0);
        check("mid_rst_state",     32'(bus.state),     32'(ST_IDLE));
        step();
        en = 1'b1;
        repeat (4) step();
        check("post_rst_idle",  32'(bus.state),   32'(ST_IDLE));
        check("post_rst_disp",  32'(bus.disp_en), 32'd1);
        check("lfsr_model_b",   32'(bus.lfsr),    32'(m_lfsr));

        // normal trial, react 20 cycles after GO
        start_trial(1'b0);
        check("wait_state",   32'(bus.state),   32'(ST_WAIT));
        check("wait_busy",    32'(bus.busy),    32'd1);
        check("wait_disp_en", 32'(bus.disp_en), 32'd0);
        wait_go("go_lat_normal", t);
        check("go_busy",    32'(bus.busy),      32'd1);
        check("go_disp_en", 32'(bus.disp_en),   32'd1);
        check("go_rect0",   32'(bus.rect_time), 32'd0);
        repeat (20) step();
        check("go_rect5",   32'(bus.rect_time), 32'd5);
        pulse(1'b0, 1'b1);
        check("show_rect",   32'(bus.rect_time), 32'd5);
        check("show_led_go", 32'(bus.led_go),    32'd0);
        check("show_state",  32'(bus.state),     32'(ST_SHOW));
        check("show_busy",   32'(bus.busy),      32'd0);
        repeat (8) step();
        check("show_hold",   32'(bus.rect_time), 32'd5);

        // early press after two ticks
        start_trial(1'b0);
        repeat (8) step();
        pulse(1'b0, 1'b1);
        exp_q.delete();
        check("early_flag",    32'(bus.too_early), 32'd1);
        check("early_disp_en", 32'(bus.disp_en),   32'd0);
        check("early_state",   32'(bus.state),     32'(ST_EARLY));
        check("early_rect",    32'(bus.rect_time), 32'd5);
        seen_go = 1'b0;
        repeat (70) begin
            step();
            if (bus.led_go) seen_go = 1'b1;
        end
        check("early_no_go",   32'(seen_go),       32'd0);
        start_trial(1'b0);
        check("early_clear",   32'(bus.too_early), 32'd0);
        check("early_restart", 32'(bus.state),     32'(ST_WAIT));

        // timeout without react
        wait_go("go_lat_timeout", t);
        repeat (79) step();
        check("to_rect19",  32'(bus.rect_time), 32'd19);
        check("to_in_go",   32'(bus.state),     32'(ST_GO));
        step();
        check("to_rect20",  32'(bus.rect_time), 32'd20);
        check("to_state",   32'(bus.state),     32'(ST_SHOW));
        check("to_led_go",  32'(bus.led_go),    32'd0);
        repeat (12) step();
        check("to_hold",    32'(bus.rect_time), 32'd20);

        // react on the delay-expiry edge
        start_trial(1'b0);
        d_peek = int'(exp_q[0]);
        repeat (TICK_DIV * d_peek - 1) step();
        pulse(1'b0, 1'b1);
        exp_q.delete();
        check("coll_exp_state",  32'(bus.state),  32'(ST_EARLY));
        check("coll_exp_led_go", 32'(bus.led_go), 32'd0);

        // react on a GO tick edge: captured without increment
        start_trial(1'b0);
        wait_go("go_lat_coll", t);
        repeat (19) step();
        pulse(1'b0, 1'b1);
        check("coll_tick_rect",  32'(bus.rect_time), 32'd4);
        check("coll_tick_state", 32'(bus.state),     32'(ST_SHOW));

        // start and react together in SHOW
        start_trial(1'b1);
        check("coll_sr_state", 32'(bus.state),     32'(ST_WAIT));
        check("coll_sr_early", 32'(bus.too_early), 32'd0);

        // eight back-to-back trials
        for (int i = 0; i < 8; i++) begin
            wait_go("go_lat_rand", got[i]);
            pulse(1'b0, 1'b1);
            if (i < 7) start_trial(1'b0);
        end
        in_range = 1'b1;
        all_eq   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (got[i] < MIN_DELAY || got[i] > MIN_DELAY + 7) in_range = 1'b0;
            if (got[i] != got[0]) all_eq = 1'b0;
        end
        check("rand_range",   32'(in_range),  32'd1);
        check("rand_not_eq",  32'(all_eq),    32'd0);
        check("lfsr_model_c", 32'(bus.lfsr),  32'(m_lfsr));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
